// File: rtl/bitty_fetch_ctrl.sv
// Instruction sequencer for the bitty core: owns the PC, fetches 16-bit words over a
// request/valid handshake, issues them with a run pulse and supervises completion.
module bitty_fetch_ctrl #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned TIMEOUT    = 16,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              run,
  output logic [15:0]       d_instr,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              timeout_err,
  output logic [15:0]       instr_count
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_MEM = 3'd2;
  localparam logic [2:0] ST_ISSUE    = 3'd3;
  localparam logic [2:0] ST_EXEC     = 3'd4;
  localparam logic [2:0] ST_HALT     = 3'd5;
  localparam logic [2:0] ST_ERROR    = 3'd6;

  localparam logic [7:0]        WD_LIMIT = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_r, state_nx_s;
  logic [ADDR_W-1:0] pc_r, pc_nx_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_nx_s;
  logic [15:0]       d_instr_r, d_instr_nx_s;
  logic [15:0]       count_r, count_nx_s;
  logic [7:0]        wd_r, wd_nx_s;
  logic              stop_r, stop_nx_s, stop_eff_s, in_flight_s;
  logic              mem_req_r, run_r, busy_r, halted_r, err_r;

  // Next-state, datapath and stop-latch decisions for the sequencer.
  always_comb begin
    state_nx_s   = state_r;
    pc_nx_s      = pc_r;
    d_instr_nx_s = d_instr_r;
    count_nx_s   = count_r;
    wd_nx_s      = wd_r;
    in_flight_s  = (state_r == ST_FETCH) || (state_r == ST_WAIT_MEM) ||
                   (state_r == ST_ISSUE) || (state_r == ST_EXEC);
    // A stop arriving in the deciding cycle itself is honoured, not deferred.
    stop_eff_s   = stop_r | (stop & in_flight_s);

    case (state_r)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_nx_s    = start_addr;
          state_nx_s = ST_FETCH;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_FETCH: state_nx_s = ST_WAIT_MEM;
      ST_WAIT_MEM: begin
        if (!mem_rvalid) begin
          state_nx_s = ST_WAIT_MEM;
        end else if (stop_eff_s) begin
          state_nx_s = ST_IDLE;
        end else if (mem_rdata == HALT_INSTR) begin
          state_nx_s = ST_HALT;
        end else begin
          d_instr_nx_s = mem_rdata;
          state_nx_s   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_nx_s    = 8'd0;
        state_nx_s = ST_EXEC;
      end
      ST_EXEC: begin
        if (done) begin
          pc_nx_s = pc_r + PC_ONE;
          if (count_r != 16'hFFFF) begin
            count_nx_s = count_r + 16'd1;
          end else begin
            count_nx_s = count_r;
          end
          state_nx_s = stop_eff_s ? ST_IDLE : ST_FETCH;
        end else if (wd_r == WD_LIMIT) begin
          state_nx_s = ST_ERROR;
        end else begin
          wd_nx_s = wd_r + 8'd1;
        end
      end
      ST_ERROR: state_nx_s = ST_ERROR;
      default:  state_nx_s = ST_IDLE;
    endcase

    if ((state_nx_s == ST_IDLE) || (state_nx_s == ST_HALT)) begin
      stop_nx_s = 1'b0;
    end else begin
      stop_nx_s = stop_eff_s;
    end

    if (state_nx_s == ST_FETCH) begin
      mem_addr_nx_s = pc_nx_s;
    end else begin
      mem_addr_nx_s = mem_addr_r;
    end
  end

  // State and registered outputs; outputs are decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      pc_r       <= '0;
      mem_addr_r <= '0;
      d_instr_r  <= 16'h0000;
      count_r    <= 16'h0000;
      wd_r       <= 8'd0;
      stop_r     <= 1'b0;
      mem_req_r  <= 1'b0;
      run_r      <= 1'b0;
      busy_r     <= 1'b0;
      halted_r   <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      pc_r       <= pc_nx_s;
      mem_addr_r <= mem_addr_nx_s;
      d_instr_r  <= d_instr_nx_s;
      count_r    <= count_nx_s;
      wd_r       <= wd_nx_s;
      stop_r     <= stop_nx_s;
      mem_req_r  <= (state_nx_s == ST_FETCH);
      run_r      <= (state_nx_s == ST_ISSUE);
      busy_r     <= (state_nx_s == ST_FETCH) || (state_nx_s == ST_WAIT_MEM) ||
                    (state_nx_s == ST_ISSUE) || (state_nx_s == ST_EXEC);
      halted_r   <= (state_nx_s == ST_HALT);
      err_r      <= (state_nx_s == ST_ERROR);
    end
  end

  assign mem_req     = mem_req_r;
  assign mem_addr    = mem_addr_r;
  assign run         = run_r;
  assign d_instr     = d_instr_r;
  assign pc          = pc_r;
  assign busy        = busy_r;
  assign halted      = halted_r;
  assign timeout_err = err_r;
  assign instr_count = count_r;

endmodule

// File: tb/tb_bitty_fetch_ctrl.sv
// Directed bench for bitty_fetch_ctrl: memory and core responders, a scoreboard of expected
// issued instructions, and step-by-step checks of PC, counters, stop, watchdog and reset.
module tb_bitty_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, mem_rvalid, done;
  logic [7:0]  start_addr;
  logic [15:0] mem_rdata;
  logic        mem_req, run, busy, halted, timeout_err;
  logic [7:0]  mem_addr, pc;
  logic [15:0] d_instr, instr_count;

  logic [15:0] mem [0:255];
  logic [15:0] exp_q [$];
  int          lat, core_lat;
  int          checks = 0, failures = 0;
  int          req_cnt = 0, run_cnt = 0, cyc = 0, run_cyc = 0, run_target = 0;
  int          req_before, run_before, err_cyc;
  logic        mem_pending = 1'b0, prev_rvalid = 1'b0;
  logic [15:0] last_d = 16'h0000;
  logic [7:0]  rsp_addr;

  bitty_fetch_ctrl dut (
    .clk(clk), .reset(rst_n), .start(start), .start_addr(start_addr), .stop(stop),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .run(run), .d_instr(d_instr), .done(done), .pc(pc), .busy(busy), .halted(halted),
    .timeout_err(timeout_err), .instr_count(instr_count)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory: answers each request after lat cycles with a single valid beat.
  initial begin
    mem_rvalid = 1'b0; mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && rst_n === 1'b1) begin
        rsp_addr = mem_addr;
        repeat (lat) @(posedge clk);
        #1 mem_rvalid = 1'b1; mem_rdata = mem[rsp_addr];
        @(posedge clk);
        #1 mem_rvalid = 1'b0; mem_rdata = 16'h0000;
      end
    end
  end

  // Core: pulses done core_lat cycles after run; core_lat=0 models a hung core.
  initial begin
    done = 1'b0;
    forever begin
      @(negedge clk);
      if (run === 1'b1 && core_lat > 0) begin
        repeat (core_lat) @(posedge clk);
        #1 done = 1'b1;
        @(posedge clk);
        #1 done = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pop on run, request counting, handshake ordering.
  initial forever begin
    @(negedge clk);
    if (rst_n !== 1'b1) begin
      mem_pending = 1'b0; prev_rvalid = 1'b0; last_d = d_instr;
    end else begin
      if (d_instr !== last_d) check("d_instr_change_after_rvalid", {31'd0, prev_rvalid}, 32'd1);
      if (run === 1'b1) begin
        run_cnt++;
        run_cyc = cyc;
        check("run_while_mem_pending", {31'd0, mem_pending}, 32'd0);
        if (exp_q.size() != 0) check("d_instr_at_run", {16'd0, d_instr}, {16'd0, exp_q.pop_front()});
        else check("run_unexpected", {31'd0, run}, 32'd0);
      end
      if (mem_req === 1'b1) begin req_cnt++; mem_pending = 1'b1; end
      if (mem_rvalid === 1'b1) mem_pending = 1'b0;
      prev_rvalid = mem_rvalid;
      last_d = d_instr;
    end
  end

  function automatic bit cond(input int sel);
    case (sel)
      0: return halted === 1'b1;
      1: return busy === 1'b0;
      2: return timeout_err === 1'b1;
      3: return run_cnt >= run_target;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int max_cyc, input string tag);
    int n = 0;
    while (!cond(sel) && n < max_cyc) begin @(negedge clk); n++; end
    check(tag, {31'd0, cond(sel)}, 32'd1);
  endtask

  task automatic start_prog(input logic [7:0] a);
    @(posedge clk); #1 start = 1'b1; start_addr = a;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pc"}, {24'd0, pc}, 32'd0);
    check({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
    check({tag, "_d_instr"}, {16'd0, d_instr}, 32'd0);
    check({tag, "_instr_count"}, {16'd0, instr_count}, 32'd0);
    check({tag, "_flags"}, {27'd0, mem_req, run, busy, halted, timeout_err}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; start_addr = 8'h00;
    lat = 1; core_lat = 2;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    #3 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic program, single-cycle memory
    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'hFFFF;
    exp_q.push_back(16'h1234); exp_q.push_back(16'h5678);
    req_before = req_cnt;
    start_prog(8'h00);
    wait_for(0, 100, "basic_halted");
    check("basic_pc", {24'd0, pc}, 32'd2);
    check("basic_count", {16'd0, instr_count}, 32'd2);
    check("basic_mem_reqs", req_cnt - req_before, 32'd3);
    check("basic_busy", {31'd0, busy}, 32'd0);

    // Same program behind a 5-cycle memory
    do_reset();
    lat = 5;
    exp_q.push_back(16'h1234); exp_q.push_back(16'h5678);
    req_before = req_cnt;
    start_prog(8'h00);
    wait_for(0, 200, "wait_halted");
    check("wait_pc", {24'd0, pc}, 32'd2);
    check("wait_count", {16'd0, instr_count}, 32'd2);
    check("wait_mem_reqs", req_cnt - req_before, 32'd3);

    // Stop during EXEC of pc=4, then stop during WAIT_MEM of pc=5
    do_reset();
    lat = 1; core_lat = 4;
    mem[4] = 16'h0A04; mem[5] = 16'h0A05;
    exp_q.push_back(16'h0A04);
    run_target = run_cnt + 1;
    start_prog(8'h04);
    wait_for(3, 20, "stop_exec_run_seen");
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_for(1, 20, "stop_exec_idle");
    check("stop_exec_pc", {24'd0, pc}, 32'd5);
    check("stop_exec_count", {16'd0, instr_count}, 32'd1);
    req_before = req_cnt;
    repeat (4) @(negedge clk);
    check("stop_exec_stays_idle", req_cnt - req_before, 32'd0);
    lat = 5;
    run_before = run_cnt;
    start_prog(8'h05);
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_for(1, 30, "stop_wait_idle");
    check("stop_wait_pc", {24'd0, pc}, 32'd5);
    check("stop_wait_no_run", run_cnt - run_before, 32'd0);
    check("stop_wait_d_instr", {16'd0, d_instr}, 32'h0A04);

    // Watchdog: hung core
    do_reset();
    lat = 1; core_lat = 0;
    mem[16] = 16'h1111; mem[17] = 16'hFFFF;
    exp_q.push_back(16'h1111);
    run_target = run_cnt + 1;
    start_prog(8'h10);
    wait_for(3, 20, "wd_run_seen");
    wait_for(2, 40, "wd_error");
    err_cyc = cyc;
    check("wd_latency", err_cyc - run_cyc, 32'd17);
    req_before = req_cnt;
    start_prog(8'h00);
    repeat (5) @(negedge clk);
    check("wd_sticky", {30'd0, timeout_err, busy}, 32'd2);
    check("wd_start_ignored", req_cnt - req_before, 32'd0);
    do_reset();
    @(negedge clk);
    check("wd_reset_clears", {31'd0, timeout_err}, 32'd0);

    // Done on the watchdog limit cycle wins
    core_lat = 16;
    exp_q.push_back(16'h1111);
    start_prog(8'h10);
    wait_for(0, 100, "wd_limit_halted");
    check("wd_limit_no_err", {31'd0, timeout_err}, 32'd0);
    check("wd_limit_count", {16'd0, instr_count}, 32'd1);
    check("wd_limit_pc", {24'd0, pc}, 32'h11);

    // PC wrap
    do_reset();
    core_lat = 1;
    mem[255] = 16'h2222; mem[0] = 16'hFFFF;
    exp_q.push_back(16'h2222);
    start_prog(8'hFF);
    wait_for(0, 100, "wrap_halted");
    check("wrap_pc", {24'd0, pc}, 32'h00);
    check("wrap_count", {16'd0, instr_count}, 32'd1);

    // Saturation: preload the counter near its ceiling
    mem[32] = 16'h3000; mem[33] = 16'h3001; mem[34] = 16'h3002; mem[35] = 16'hFFFF;
    @(posedge clk); #1 force dut.count_r = 16'hFFFD;
    @(negedge clk); release dut.count_r;
    @(negedge clk);
    exp_q.push_back(16'h3000); exp_q.push_back(16'h3001); exp_q.push_back(16'h3002);
    start_prog(8'h20);
    wait_for(0, 200, "sat_halted");
    check("sat_count", {16'd0, instr_count}, 32'hFFFF);

    // Asynchronous reset mid-EXEC
    do_reset();
    core_lat = 0;
    mem[48] = 16'h4444; mem[49] = 16'hFFFF;
    exp_q.push_back(16'h4444);
    run_target = run_cnt + 1;
    start_prog(8'h30);
    wait_for(3, 20, "areset_run_seen");
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_zero("areset");
    @(negedge clk); #2 rst_n = 1'b1;
    req_before = req_cnt;
    repeat (5) @(negedge clk);
    check("areset_idle_busy", {31'd0, busy}, 32'd0);
    check("areset_idle_no_req", req_cnt - req_before, 32'd0);
    core_lat = 1;
    exp_q.push_back(16'h4444);
    start_prog(8'h30);
    wait_for(0, 100, "areset_restart_halted");
    check("areset_restart_count", {16'd0, instr_count}, 32'd1);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bitty_fetch_ctrl.md
Name: bitty_fetch_ctrl

Overview:
Instruction sequencer that sits in front of the bitty core. It owns the program counter and reads 16-bit instructions from an instruction memory using a request/valid handshake. Each instruction is presented on d_instr with a one-cycle run pulse, and the block waits for the core's done before fetching the next one. It also detects a halt encoding, honours a graceful stop request, and flags cores that never assert done.

Parameters:
ADDR_W, 8, program counter / memory address width; PC wraps modulo 2^ADDR_W
TIMEOUT, 16, maximum cycles in EXEC without done before error (legal range 2..255)
HALT_INSTR, 16'hFFFF, instruction encoding that halts sequencing; it is never issued to the core

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  in IDLE or HALT: load pc from start_addr and begin fetching
start_addr  in  ADDR_W  first instruction address
stop  in  1  request stop at the next instruction boundary; latched internally
mem_req  out  1  one-cycle read request
mem_addr  out  ADDR_W  read address, valid while mem_req=1
mem_rdata  in  16  instruction data
mem_rvalid  in  1  mem_rdata valid; sampled only in WAIT_MEM
run  out  1  one-cycle start pulse to the core
d_instr  out  16  instruction to the core; held stable from ISSUE through EXEC
done  in  1  core finished the current instruction; sampled only in EXEC
pc  out  ADDR_W  current program counter
busy  out  1  high in FETCH, WAIT_MEM, ISSUE and EXEC
halted  out  1  high in HALT
timeout_err  out  1  high in ERROR
instr_count  out  16  instructions retired; saturates at 16'hFFFF

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. pc, mem_addr, d_instr, instr_count = 0. mem_req, run, busy, halted, timeout_err = 0. The stop latch and the watchdog counter are cleared.
- All outputs are registered. Reset mid-operation aborts everything immediately; no memory read or run pulse is completed.
- IDLE: start=1 loads pc<=start_addr and moves to FETCH. stop has no effect.
- FETCH: mem_req=1 and mem_addr=pc for exactly one cycle, then WAIT_MEM.
- WAIT_MEM: hold until mem_rvalid=1. The earliest mem_rvalid is the cycle after mem_req, and there is no upper bound. When mem_rvalid=1:
  - If the stop latch is set: discard the data, clear the latch, move to IDLE. pc is not advanced.
  - Else if mem_rdata==HALT_INSTR: move to HALT. d_instr is unchanged and pc is not advanced.
  - Else: d_instr<=mem_rdata and move to ISSUE.
- ISSUE: run=1 for one cycle, watchdog cleared to 0, then EXEC.
- EXEC: the watchdog increments each cycle. When done=1:
  - pc<=pc+1, wrapping from 2^ADDR_W-1 to 0.
  - instr_count is incremented, saturating.
  - If the stop latch is set: clear it and move to IDLE. Otherwise move to FETCH.
- EXEC timeout: if the watchdog reaches TIMEOUT without done, move to ERROR. If done arrives in the same cycle the watchdog hits the limit, done wins.
- HALT: halted=1, busy=0. start=1 loads pc<=start_addr, clears halted and moves to FETCH. stop is ignored.
- ERROR: timeout_err=1 (sticky), busy=0. Only reset exits ERROR; start and stop are ignored.
- stop latch: set by stop=1 in FETCH, WAIT_MEM, ISSUE or EXEC. Cleared when consumed, and on entry to IDLE or HALT.
- Ignored inputs: done outside EXEC, mem_rvalid outside WAIT_MEM, and start while busy.
- Latency: start at cycle 0 gives mem_req at cycle 1. With mem_rvalid at cycle 2, run is at cycle 3. done at cycle N gives the next mem_req at cycle N+1.

Test Plan:
- Basic program: memory {0:16'h1234, 1:16'h5678, 2:HALT_INSTR}, 1-cycle memory, core done 2 cycles after run; start, start_addr=0. Expect run pulses with d_instr 16'h1234 then 16'h5678, halted=1, pc=2, instr_count=2, and exactly 3 mem_req.
- Wait states: mem_rvalid delayed 5 cycles. Expect run to stay low through the wait and d_instr to change only when mem_rvalid=1; final results match the basic program.
- Stop at boundary: assert stop for 1 cycle mid-EXEC of the instruction at pc=4. Expect return to IDLE after done with pc=5 and busy=0. Stop asserted in WAIT_MEM gives IDLE with pc unchanged and no run pulse.
- Watchdog: core never asserts done with TIMEOUT=16. Expect timeout_err=1 exactly 16 cycles after entering EXEC; start ignored afterwards; reset clears it. Separately, done on the limit cycle must give no error.
- PC wrap and saturation: start_addr=8'hFF with a non-halt instruction. Expect pc=8'h00 after done. Preload a long program and check instr_count stops at 16'hFFFF.
- Async reset mid-EXEC (reset low between edges): all outputs are 0 immediately; after release, IDLE until start.
